// File: rtl/mfcc_pkg.sv
// Shared constants and FSM state type for the MFCC mel-filterbank sequencer.
package mfcc_pkg;

   localparam int unsigned NUM_BINS     = 256;
   localparam logic [8:0]  ROM_IDX_BASE = 9'd256;
   localparam logic [7:0]  IDX_NONE     = 8'hFF;

   typedef enum logic [2:0] {
      S_IN,
      S_IDX,
      S_WGT,
      S_ACC,
      S_OUT
   } state_t;

endpackage

// File: rtl/mfcc_melbank_ctrl_if.sv
// Bin input stream, weight ROM port and filter-energy output stream of the melbank sequencer.
interface mfcc_melbank_ctrl_if #(
   parameter int unsigned P_W   = 32,
   parameter int unsigned ACC_W = 48
);

   logic             s_valid;
   logic             s_ready;
   logic [P_W-1:0]   s_data;
   logic             s_last;
   logic [8:0]       rom_addr;
   logic [7:0]       rom_data;
   logic             m_valid;
   logic             m_ready;
   logic [ACC_W-1:0] m_data;
   logic [4:0]       m_idx;
   logic             m_last;
   logic             busy;
   logic             frame_err;

   // Design side
   modport slave (
      input  s_valid, s_data, s_last, rom_data, m_ready,
      output s_ready, rom_addr, m_valid, m_data, m_idx, m_last, busy, frame_err
   );

   // Environment side (spectrum source, ROM, log/DCT sink)
   modport master (
      output s_valid, s_data, s_last, rom_data, m_ready,
      input  s_ready, rom_addr, m_valid, m_data, m_idx, m_last, busy, frame_err
   );

endinterface

// File: rtl/mfcc_melbank_acc.sv
// Filter accumulator bank: rising/falling add ports, clear port and a look-ahead read port.
// MELBANK_ACC_SAT_EN defined: updates saturate at 2^ACC_W-1; otherwise they wrap.
module mfcc_melbank_acc #(
   parameter int unsigned NUM_FILT = 20,
   parameter int unsigned ACC_W    = 48,
   parameter int unsigned PROD_W   = 41
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rise_en,
   input  logic [4:0]        rise_idx,
   input  logic [PROD_W-1:0] rise_val,
   input  logic              fall_en,
   input  logic [4:0]        fall_idx,
   input  logic [PROD_W-1:0] fall_val,
   input  logic              clr_en,
   input  logic [4:0]        clr_idx,
   input  logic [4:0]        rd_idx,
   output logic [ACC_W-1:0]  rd_data
);

   localparam int unsigned SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
`ifdef MELBANK_ACC_SAT_EN
   localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});
`endif

   logic [ACC_W-1:0] acc     [NUM_FILT];
   logic [ACC_W-1:0] acc_nxt [NUM_FILT];

   function automatic logic [ACC_W-1:0] upd(input logic [ACC_W-1:0] a, input logic [SUM_W-1:0] add);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + add;
`ifdef MELBANK_ACC_SAT_EN
      return (sum > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(sum);
`else
      return ACC_W'(sum);
`endif
   endfunction

   // Next value of every accumulator; the read port looks at it so an in-flight update is visible
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_FILT; i++) begin
         acc_nxt[i] = upd(acc[i],
                          (rise_en && rise_idx == 5'(i)) ? SUM_W'(rise_val) :
                          (fall_en && fall_idx == 5'(i)) ? SUM_W'(fall_val) : SUM_W'(0));
         if (clr_en && clr_idx == 5'(i)) acc_nxt[i] = '0;
         if (rd_idx == 5'(i)) rd_data = acc_nxt[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FILT; i++) begin
         if (rst) acc[i] <= '0;
         else     acc[i] <= acc_nxt[i];
      end
   end

endmodule

// File: rtl/mfcc_melbank_ctrl.sv
// MFCC mel-filterbank sequencer: bins in, two-filter weighting via ROM, NUM_FILT energies out.
// MELBANK_ACC_SAT_EN selects saturating accumulation (see mfcc_melbank_acc).
module mfcc_melbank_ctrl
   import mfcc_pkg::*;
#(
   parameter int unsigned NUM_FILT = 20,
   parameter int unsigned P_W      = 32,
   parameter int unsigned ACC_W    = 48
) (
   input  logic                clk,
   input  logic                rst,
   mfcc_melbank_ctrl_if.slave  bus
);

   localparam int unsigned PROD_W   = P_W + 9;
   localparam logic [8:0]  BIN_SAT  = 9'(NUM_BINS);
   localparam logic [4:0]  LAST_IDX = 5'(NUM_FILT - 1);

   state_t            state, state_nxt;
   logic [8:0]        bin, bin_d, beat_bin;
   logic [P_W-1:0]    p_q;
   logic              last_q;
   logic [7:0]        idx_q, w_q;

   logic              s_ready_d, m_valid_d, m_last_d, busy_d, frame_err_d;
   logic [8:0]        rom_addr_d;
   logic [ACC_W-1:0]  m_data_d;
   logic [4:0]        m_idx_d;

   logic              s_hs, m_hs, bin_ok;
   logic              rise_en, fall_en, clr_en;
   logic [PROD_W-1:0] rise_val, fall_val;
   logic [4:0]        rd_idx;
   logic [ACC_W-1:0]  rd_data;

   assign s_hs = bus.s_valid & bus.s_ready;
   assign m_hs = bus.m_valid & bus.m_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IN:    if (s_hs) state_nxt = S_IDX;
         S_IDX:   state_nxt = S_WGT;
         S_WGT:   state_nxt = S_ACC;
         S_ACC:   state_nxt = last_q ? S_OUT : S_IN;
         S_OUT:   if (m_hs && bus.m_last) state_nxt = S_IN;
         default: state_nxt = S_IN;
      endcase
   end

   // Look ahead one filter so the next energy is ready on the handshake edge
   assign rd_idx = (state == S_OUT) ? bus.m_idx + 5'd1 : 5'd0;

   always_comb begin
      bin_d       = bin;
      rom_addr_d  = bus.rom_addr;
      m_valid_d   = bus.m_valid;
      m_data_d    = bus.m_data;
      m_idx_d     = bus.m_idx;
      m_last_d    = bus.m_last;
      s_ready_d   = (state_nxt == S_IN);
      frame_err_d = (state_nxt == S_ACC) && last_q && (beat_bin != 9'd255);
      if (s_hs) begin
         bin_d      = (bin == BIN_SAT) ? bin : bin + 9'd1;
         rom_addr_d = ROM_IDX_BASE | {1'b0, bin[7:0]};
      end
      if (state == S_IDX) rom_addr_d = {1'b0, beat_bin[7:0]};
      if (state == S_ACC && last_q) begin
         m_valid_d = 1'b1;
         m_idx_d   = 5'd0;
         m_last_d  = (LAST_IDX == 5'd0);
         m_data_d  = rd_data;
      end
      if (state == S_OUT && m_hs) begin
         if (bus.m_last) begin
            m_valid_d = 1'b0;
            m_idx_d   = 5'd0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
            bin_d     = 9'd0;
         end else begin
            m_idx_d  = rd_idx;
            m_last_d = (rd_idx == LAST_IDX);
            m_data_d = rd_data;
         end
      end
      busy_d = (state_nxt != S_IN) || (bin_d != 9'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.s_ready   <= 1'b0;
         bus.rom_addr  <= 9'd0;
         bus.m_valid   <= 1'b0;
         bus.m_data    <= '0;
         bus.m_idx     <= 5'd0;
         bus.m_last    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.frame_err <= 1'b0;
         bin           <= 9'd0;
      end else begin
         bus.s_ready   <= s_ready_d;
         bus.rom_addr  <= rom_addr_d;
         bus.m_valid   <= m_valid_d;
         bus.m_data    <= m_data_d;
         bus.m_idx     <= m_idx_d;
         bus.m_last    <= m_last_d;
         bus.busy      <= busy_d;
         bus.frame_err <= frame_err_d;
         bin           <= bin_d;
      end
   end

   // Per-beat capture: sample on handshake, then index and weight from the ROM
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q      <= '0;
         last_q   <= 1'b0;
         beat_bin <= 9'd0;
         idx_q    <= 8'd0;
         w_q      <= 8'd0;
      end else begin
         if (s_hs) begin
            p_q      <= bus.s_data;
            last_q   <= bus.s_last;
            beat_bin <= bin;
         end
         if (state == S_IDX) idx_q <= bus.rom_data;
         if (state == S_WGT) w_q   <= bus.rom_data;
      end
   end

   // Beats past the last ROM bin are consumed but never weighted
   assign bin_ok   = (state == S_ACC) && !beat_bin[8] && (idx_q != IDX_NONE);
   assign rise_en  = bin_ok && (idx_q < 8'(NUM_FILT));
   assign fall_en  = bin_ok && (idx_q >= 8'd1) && (idx_q <= 8'(NUM_FILT));
   assign rise_val = PROD_W'(p_q) * PROD_W'(w_q);
   assign fall_val = PROD_W'(p_q) * PROD_W'(9'd256 - {1'b0, w_q});
   assign clr_en   = (state == S_OUT) && m_hs;

   mfcc_melbank_acc #(
      .NUM_FILT (NUM_FILT),
      .ACC_W    (ACC_W),
      .PROD_W   (PROD_W)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .rise_en  (rise_en),
      .rise_idx (idx_q[4:0]),
      .rise_val (rise_val),
      .fall_en  (fall_en),
      .fall_idx (5'(idx_q - 8'd1)),
      .fall_val (fall_val),
      .clr_en   (clr_en),
      .clr_idx  (bus.m_idx),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

endmodule

// File: doc/mfcc_melbank_ctrl.md
# mfcc_melbank_ctrl

Sequencer for the MFCC mel-filterbank stage. Accepts one frame of FFT power-spectrum bins as a valid/ready stream and drives the 512×8 asynchronous-read mel weight ROM. Applies each bin to its two overlapping triangular filters through an internal accumulator bank, then streams out the NUM_FILT filter energies. Sits between the FFT power calculation and the log/DCT stage.

## Interface
- NUM_FILT, 20, number of mel filters (≤ 32)
- P_W, 32, power-spectrum sample width (unsigned)
- ACC_W, 48, accumulator/output width (unsigned)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  bin sample valid
- s_ready  out  1  controller accepts bin
- s_data  in  P_W  bin power
- s_last  in  1  last bin of frame
- rom_addr  out  9  weight ROM address (registered)
- rom_data  in  8  weight ROM read data, combinational from rom_addr
- m_valid  out  1  filter energy valid
- m_ready  in  1  downstream accepts
- m_data  out  ACC_W  filter energy (scale 2^8)
- m_idx  out  5  filter index 0..NUM_FILT-1
- m_last  out  1  high with filter NUM_FILT-1
- busy  out  1  frame in progress or output pending
- frame_err  out  1  one-cycle pulse on malformed frame

## Operation
- ROM layout: addr 0..255 = rising weight w[k] of bin k; addr 256..511 = filter index idx[k]. IDX_NONE = 8'hFF: bin outside all filters.
- Per bin k with power p, when idx[k] ≠ IDX_NONE:
  - acc[idx] += p·w if idx < NUM_FILT.
  - acc[idx−1] += p·(256−w) if 1 ≤ idx ≤ NUM_FILT.
  - Any other idx value contributes nothing.
- (256−w) is 9 bits wide; products are P_W+9 bits, zero-extended to ACC_W.
- Bin counter bin[7:0] starts at 0 and increments on every accepted beat.
- Beats with bin ≥ 256 (counter saturated at 256, 9-bit) are accepted and discarded.
- FSM:
  - S_IN: s_ready=1. On handshake, latch s_data/s_last and go to S_IDX.
  - S_IDX: rom_addr=256+bin; latch rom_data as idx; go to S_WGT.
  - S_WGT: rom_addr=bin; latch w; go to S_ACC.
  - S_ACC: update accumulators. Go to S_OUT if latched last, else S_IN.
  - S_OUT: present acc[m_idx], m_idx counting 0..NUM_FILT-1. On each handshake, clear that accumulator. After handshake with m_last, go to S_IN and reset bin to 0.
- frame_err pulses in S_ACC of the last beat if that beat's bin ≠ 255 (short or long frame). The output phase still runs.
- busy = (state ≠ S_IN) or (bin ≠ 0).

## Timing
- Reset values: s_ready=0 during rst, 1 in the first cycle after release. m_valid=0, m_data=0, m_idx=0, m_last=0, rom_addr=0, busy=0, frame_err=0. Accumulators, bin counter and state are cleared.
- Throughput: 4 cycles per bin minimum; full frame 1024 cycles plus NUM_FILT output beats.
- First m_valid: 1 cycle after S_ACC of the last beat.
- m_data, m_idx and m_last are held stable while m_valid=1 and m_ready=0. m_ready back-pressure stalls only S_OUT.
- s_ready=0 in every state except S_IN; s_valid held high outside S_IN is not consumed.
- rom_addr is registered. ROM data is sampled in the same cycle the address is presented (zero-latency ROM).
- Reset mid-frame or mid-output: partial results are discarded, no m_valid, and the next frame starts at bin 0.

## Configuration
- MELBANK_ACC_SAT_EN defined: each accumulator update saturates at 2^ACC_W−1.
- Undefined: updates wrap modulo 2^ACC_W.
- No other behaviour changes.

## Structure
- Shared package mfcc_pkg holds:
  - NUM_BINS=256, ROM_IDX_BASE=9'd256, IDX_NONE=8'hFF
  - state enum (S_IN, S_IDX, S_WGT, S_ACC, S_OUT)
- Sub-module mfcc_melbank_acc: NUM_FILT×ACC_W accumulator bank with dual-port add (rising/falling), read-and-clear port, and optional saturation.
- The weight ROM is instantiated by the parent, outside this block.

## Test plan
- Single bin: ROM bin 10 idx=3, w=64, other bins IDX_NONE; p=100 at bin 10 of a 256-beat frame -> acc3=6400, acc2=19200, all other outputs 0, m_last on m_idx=19.
- Edge indices: idx=0, w=128, p=2 -> only acc0 += 256. idx=20, w=0, p=1 -> only acc19 += 256. idx=21 -> no change.
- Back-pressure: m_ready toggling 1/0 each cycle -> 20 outputs in order, values stable while stalled, s_ready=0 until the last handshake.
- Frame errors: s_last at beat 100 -> frame_err pulse, outputs valid. 300-beat frame -> beats 256..299 ignored and frame_err pulses.
- Saturation: ACC_W=16, p=0xFFFF, w=255 on 4 bins into filter 0 -> 0xFFFF with MELBANK_ACC_SAT_EN, wrapped sum without it.
- Reset: rst asserted at bin 50 and in S_OUT at m_idx=7 -> all outputs return to reset values, and the next clean frame produces correct sums.
